// File: rtl/traffic_light_multi_pkg.sv
// Shared phase encoding and lamp patterns for the multi-direction traffic controller.
package traffic_pkg;

   typedef enum logic [2:0] {
      GREEN  = 3'd0,
      YELLOW = 3'd1,
      ALLRED = 3'd2,
      PED    = 3'd3,
      EMG    = 3'd4
   } tl_state_e;

   localparam logic [2:0] LAMP_RED = 3'b100;
   localparam logic [2:0] LAMP_YEL = 3'b010;
   localparam logic [2:0] LAMP_GRN = 3'b001;

   // Lamp pattern for one approach; only the served direction may leave red.
   function automatic logic [2:0] lamp_for(input tl_state_e st, input logic served);
      logic [2:0] lamp;
      lamp = LAMP_RED;
      case (st)
         GREEN, EMG: if (served) lamp = LAMP_GRN;
         YELLOW:     if (served) lamp = LAMP_YEL;
         default:    lamp = LAMP_RED;
      endcase
      return lamp;
   endfunction

endpackage

// File: rtl/tl_down_counter.sv
// Loadable down-counter that stops at zero; load wins over the decrement.
module tl_down_counter #(
   parameter int               CNT_W   = 4,
   parameter logic [CNT_W-1:0] RST_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_en,
   input  logic             i_load,
   input  logic [CNT_W-1:0] i_load_val,
   output logic [CNT_W-1:0] o_count,
   output logic             o_zero
);

   logic [CNT_W-1:0] r_count;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_count <= RST_VAL;
      end else if (i_en) begin
         if (i_load)
            r_count <= i_load_val;
         else if (r_count != '0)
            r_count <= r_count - CNT_W'(1);
      end
   end

   assign o_count = r_count;
   assign o_zero  = (r_count == '0);

endmodule

// File: rtl/traffic_light_multi.sv
// Round-robin intersection controller with pedestrian walk phase and emergency override.
module traffic_light_multi #(
   parameter int  NUM_DIR  = 4,
   parameter int  CNT_W    = 4,
   parameter int  GREEN_T  = 10,
   parameter int  YELLOW_T = 3,
   parameter int  ALLRED_T = 2,
   parameter int  PED_T    = 6,
   localparam int DIR_W    = $clog2(NUM_DIR)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic                 ped_req,
   input  logic                 emg_req,
   input  logic [DIR_W-1:0]     emg_dir,
   output logic [2:0]           state,
   output logic [CNT_W-1:0]     count,
   output logic [DIR_W-1:0]     dir,
   output logic [3*NUM_DIR-1:0] light,
   output logic                 ped_walk
);

   import traffic_pkg::*;

   localparam logic [CNT_W-1:0] GREEN_LD  = CNT_W'(GREEN_T - 1);
   localparam logic [CNT_W-1:0] YELLOW_LD = CNT_W'(YELLOW_T - 1);
   localparam logic [CNT_W-1:0] ALLRED_LD = CNT_W'(ALLRED_T - 1);
   localparam logic [CNT_W-1:0] PED_LD    = CNT_W'(PED_T - 1);
   localparam logic [DIR_W-1:0] LAST_DIR  = DIR_W'(NUM_DIR - 1);

   // One bit per encodable emg_dir value, set where that value names a real approach.
   localparam int               DIR_SPAN = 1 << DIR_W;
   localparam logic [DIR_SPAN-1:0] DIR_OK = DIR_SPAN'((64'd1 << NUM_DIR) - 64'd1);

   tl_state_e        r_state;
   tl_state_e        w_state_nxt;
   logic [DIR_W-1:0] r_dir;
   logic [DIR_W-1:0] w_dir_nxt;
   logic             r_ped_pending;
   logic             w_enter_ped;
   logic             w_load;
   logic [CNT_W-1:0] w_load_val;
   logic [CNT_W-1:0] w_count;
   logic             w_zero;
   logic             w_emg_valid;
   logic             w_emg_here;

   assign w_emg_valid = emg_req & DIR_OK[emg_dir];
   assign w_emg_here  = w_emg_valid && (emg_dir == r_dir);

   tl_down_counter #(
      .CNT_W   (CNT_W),
      .RST_VAL (ALLRED_LD)
   ) u_phase_cnt (
      .clk        (clk),
      .rst        (rst),
      .i_en       (en),
      .i_load     (w_load),
      .i_load_val (w_load_val),
      .o_count    (w_count),
      .o_zero     (w_zero)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_dir_nxt   = r_dir;
      w_load      = 1'b0;
      w_load_val  = '0;
      w_enter_ped = 1'b0;
      if (en) begin
         case (r_state)
            GREEN: begin
               if (w_emg_here) begin
                  w_state_nxt = EMG;
                  w_load      = 1'b1;
               end else if (w_emg_valid || w_zero) begin
                  w_state_nxt = YELLOW;
                  w_load      = 1'b1;
                  w_load_val  = YELLOW_LD;
               end
            end
            YELLOW: begin
               if (w_zero) begin
                  w_state_nxt = ALLRED;
                  w_load      = 1'b1;
                  w_load_val  = ALLRED_LD;
               end
            end
            PED: begin
               if (w_emg_valid || w_zero) begin
                  w_state_nxt = ALLRED;
                  w_load      = 1'b1;
                  w_load_val  = ALLRED_LD;
               end
            end
            ALLRED: begin
               // Clearance done: emergency outranks a waiting walk, which outranks rotation.
               if (w_zero) begin
                  w_load = 1'b1;
                  if (w_emg_valid) begin
                     w_state_nxt = EMG;
                     w_dir_nxt   = emg_dir;
                  end else if (r_ped_pending) begin
                     w_state_nxt = PED;
                     w_load_val  = PED_LD;
                     w_enter_ped = 1'b1;
                  end else begin
                     w_state_nxt = GREEN;
                     w_load_val  = GREEN_LD;
                     w_dir_nxt   = (r_dir == LAST_DIR) ? '0 : r_dir + DIR_W'(1);
                  end
               end
            end
            EMG: begin
               w_load = 1'b1;
               if (!w_emg_here) begin
                  w_state_nxt = YELLOW;
                  w_load_val  = YELLOW_LD;
               end
            end
            default: begin
               w_state_nxt = ALLRED;
               w_load      = 1'b1;
               w_load_val  = ALLRED_LD;
            end
         endcase
      end
   end

   // The walk request latch keeps listening while frozen; a request coincident with entering PED is served by it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state       <= ALLRED;
         r_dir         <= LAST_DIR;
         r_ped_pending <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_dir         <= w_dir_nxt;
         r_ped_pending <= w_enter_ped ? 1'b0 : (r_ped_pending | ped_req);
      end
   end

   always_comb begin
      light = '0;
      for (int d = 0; d < NUM_DIR; d++)
         light[3*d +: 3] = lamp_for(r_state, DIR_W'(d) == r_dir);
   end

   assign state    = r_state;
   assign count    = w_count;
   assign dir      = r_dir;
   assign ped_walk = (r_state == PED);

endmodule
